// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage hazard/stall controller with DMA hold handshake
//
// Inserts one ID/EX bubble on an unresolvable load-use hazard. Flushes wrong-path
// instructions on a taken branch. Runs the CPU side of the HRQ/HLDA handshake:
// it drains EX/MEM, then freezes the pipeline and grants the bus. It also keeps a
// saturating count of the cycles in which the PC is held.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   rs_ID, rt_ID         source register fields of the instruction in ID
//   usesRt_ID            the ID instruction reads rt
//   memRead_EX           the EX instruction is a load
//   regFileWriteAddr_EX  destination register of the EX instruction
//   branchTaken_EX       the branch in EX resolved taken
//   memAccess_MEM        MEM is performing a data-memory access
//   hrq                  DMA hold request
//   hlda                 registered hold acknowledge
//   pcWrite, ifidWrite   PC and IF/ID load enables
//   ifidFlush, idexFlush clear IF/ID, inject a bubble into ID/EX
//   pipeFreeze           hold EX/MEM and MEM/WB and suppress memory accesses
//   stallCycles          saturating count of cycles with pcWrite low
module hazard_stall_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             usesRt_ID,
    input  logic             memRead_EX,
    input  logic [4:0]       regFileWriteAddr_EX,
    input  logic             branchTaken_EX,
    input  logic             memAccess_MEM,
    input  logic             hrq,
    output logic             hlda,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             pipeFreeze,
    output logic [CNT_W-1:0] stallCycles
);

    localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              hlda_q, hlda_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              load_use;

    // Register 0 is never a real dependency.
    assign load_use = memRead_EX && (regFileWriteAddr_EX != 5'd0) &&
                      ((regFileWriteAddr_EX == rs_ID) ||
                       (usesRt_ID && regFileWriteAddr_EX == rt_ID));

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        hlda_d     = hlda_q;
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        pipeFreeze = 1'b0;
        case (state_q)
            RUN: begin
                if (branchTaken_EX) begin
                    ifidFlush = 1'b1;
                    idexFlush = 1'b1;
                end else if (load_use) begin
                    pcWrite   = 1'b0;
                    ifidWrite = 1'b0;
                    idexFlush = 1'b1;
                end
                if (hrq) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            DRAIN: begin
                // A taken branch still redirects the PC while EX/MEM empty out.
                pcWrite   = branchTaken_EX;
                ifidFlush = branchTaken_EX;
                ifidWrite = 1'b0;
                idexFlush = 1'b1;
                drain_d   = (drain_q == '0) ? drain_q : drain_q - 1'b1;
                if (!hrq)
                    state_d = RUN;
                else if (drain_q == '0 && !memAccess_MEM) begin
                    state_d = HOLD;
                    hlda_d  = 1'b1;
                end
            end
            HOLD: begin
                pcWrite    = 1'b0;
                ifidWrite  = 1'b0;
                idexFlush  = 1'b1;
                pipeFreeze = 1'b1;
                if (!hrq) begin
                    state_d = RUN;
                    hlda_d  = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
                hlda_d  = 1'b0;
            end
        endcase
        stall_d = (!pcWrite && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            drain_q <= '0;
            hlda_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            hlda_q  <= hlda_d;
            stall_q <= stall_d;
        end
    end

    assign hlda        = hlda_q;
    assign stallCycles = stall_q;

endmodule
